// File: rtl/legv8_sign_extend_if.sv
// Interface bundle for legv8_sign_extend: the instruction input handshake
// (valid_i/instr_i) and the registered immediate result (valid_o/imm_o/fmt_o).
// The master side feeds instructions; the slave side is the extender itself.
interface legv8_sign_extend_if;
    logic        valid_i;
    logic [31:0] instr_i;
    logic        valid_o;
    logic [63:0] imm_o;
    logic [2:0]  fmt_o;

    modport master (
        output valid_i,
        output instr_i,
        input  valid_o,
        input  imm_o,
        input  fmt_o
    );

    modport slave (
        input  valid_i,
        input  instr_i,
        output valid_o,
        output imm_o,
        output fmt_o
    );
endinterface

// File: rtl/legv8_sign_extend.sv
// legv8_sign_extend: LEGv8 immediate extractor/extender with one cycle latency.
// Decodes the instruction format from its opcode bits, picks that format's
// immediate field, extends it to 64 bits and registers it with the format code.
// Branch offsets leave here unshifted; the word shift lives in the branch adder.
//
// Build option: define LEGV8_SIGNED_OFFSET_EN to sign-extend the imm26, imm19
// and imm9 fields. Left undefined, those fields are zero-extended. The I-format
// imm12 is zero-extended in both builds.
module legv8_sign_extend (
    input  logic                   clk,
    input  logic                   rst_n,
    legv8_sign_extend_if.slave     bus
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_B     = 3'd1,
        FMT_CB    = 3'd2,
        FMT_BCOND = 3'd3,
        FMT_D     = 3'd4,
        FMT_I     = 3'd5
    } fmt_e;

    logic [31:0] instr;
    logic [63:0] imm26_x;
    logic [63:0] imm19_x;
    logic [63:0] imm9_x;
    logic [63:0] imm12_x;

    logic [63:0] imm_d, imm_q;
    fmt_e        fmt_d, fmt_q;
    logic        valid_q;

    // Register numbers (Rt/Rd) sit in bits [4:0] and never reach the outputs.
    logic        unused_reg_bits;

    assign instr           = bus.instr_i;
    assign unused_reg_bits = ^instr[4:0];

`ifdef LEGV8_SIGNED_OFFSET_EN
    // Offsets are two's complement: replicate the field MSB up to bit 63.
    assign imm26_x = {{38{instr[25]}}, instr[25:0]};
    assign imm19_x = {{45{instr[23]}}, instr[23:5]};
    assign imm9_x  = {{55{instr[20]}}, instr[20:12]};
`else
    // Offsets are treated as unsigned magnitudes.
    assign imm26_x = {38'd0, instr[25:0]};
    assign imm19_x = {45'd0, instr[23:5]};
    assign imm9_x  = {55'd0, instr[20:12]};
`endif

    // Logical/arithmetic immediates are always unsigned.
    assign imm12_x = {52'd0, instr[21:10]};

    // Priority decode of the format and selection of its extended field.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the if/else chain can leave it unassigned and infer a latch.
        fmt_d = FMT_NONE;
        imm_d = 64'd0;
        if (instr[30:26] == 5'b00101) begin
            fmt_d = FMT_B;
            imm_d = imm26_x;
        end else if (instr[31:25] == 7'b1011010) begin
            fmt_d = FMT_CB;
            imm_d = imm19_x;
        end else if (instr[31:24] == 8'b01010100) begin
            fmt_d = FMT_BCOND;
            imm_d = imm19_x;
        end else if (instr[29:24] == 6'b111000) begin
            fmt_d = FMT_D;
            imm_d = imm9_x;
        end else if (((instr[28:24] == 5'b10001) || (instr[28:24] == 5'b10010))
                     && (instr[23:22] == 2'b00)) begin
            fmt_d = FMT_I;
            imm_d = imm12_x;
        end
    end

    // Capture the decoded result on valid cycles; valid_o tracks valid_i.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            imm_q   <= 64'd0;
            fmt_q   <= FMT_NONE;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.valid_i;
            if (bus.valid_i) begin
                imm_q <= imm_d;
                fmt_q <= fmt_d;
            end
        end
    end

    assign bus.imm_o   = imm_q;
    assign bus.fmt_o   = fmt_q;
    assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_legv8_sign_extend.sv
// Directed testbench for legv8_sign_extend. Expected immediates are
// hand-computed; offsets that depend on LEGV8_SIGNED_OFFSET_EN carry both values.
module tb_legv8_sign_extend;

    logic clk;
    logic rst_n;

    legv8_sign_extend_if bus ();

    legv8_sign_extend dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one input cycle at the falling edge, then check outputs just after
    // the next rising edge (one cycle of latency).
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic exp_v, input logic [2:0] exp_fmt,
                        input logic [63:0] exp_imm);
        @(negedge clk);
        bus.valid_i = v;
        bus.instr_i = ins;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, {63'd0, bus.valid_o}, {63'd0, exp_v});
        check({tag, ".fmt"},   {61'd0, bus.fmt_o},   {61'd0, exp_fmt});
        check({tag, ".imm"},   bus.imm_o,            exp_imm);
    endtask

    // Hand-built instruction words.
    localparam logic [31:0] LDUR5    = {11'b11111000010, 9'd5,    2'b00, 5'd1, 5'd2};
    localparam logic [31:0] LDUR5_B  = {11'b11111000010, 9'd5,    2'b00, 5'd31, 5'd17};
    localparam logic [31:0] LDURB_M1 = {11'b00111000010, 9'h1FF,  2'b00, 5'd1, 5'd2};
    localparam logic [31:0] ADDI3    = {10'b1001000100,  12'd3,   5'd1, 5'd2};
    localparam logic [31:0] ORRI_FFF = {10'b1011001000,  12'hFFF, 5'd3, 5'd4};
    localparam logic [31:0] B128     = {6'b000101, 26'd128};
    localparam logic [31:0] BL_M1    = {6'b100101, 26'h3FF_FFFF};
    localparam logic [31:0] CBNZ16   = {8'b10110101, 19'd16, 5'd0};
    localparam logic [31:0] CBZ_NEG  = {8'b10110100, 19'h40000, 5'd31};
    localparam logic [31:0] BCOND_M1 = {8'b01010100, 19'h7FFFF, 5'd0};
    localparam logic [31:0] ADD_R    = 32'h8B020020;

`ifdef LEGV8_SIGNED_OFFSET_EN
    localparam logic [63:0] EXP_LDURB = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_BL    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_CBZ   = 64'hFFFF_FFFF_FFFC_0000;
    localparam logic [63:0] EXP_BCOND = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam logic [63:0] EXP_LDURB = 64'h1FF;
    localparam logic [63:0] EXP_BL    = 64'h3FF_FFFF;
    localparam logic [63:0] EXP_CBZ   = 64'h4_0000;
    localparam logic [63:0] EXP_BCOND = 64'h7_FFFF;
`endif

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bus.valid_i = 1'b1;
        bus.instr_i = LDUR5;

        // Reset held across several edges with valid input present.
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", {63'd0, bus.valid_o}, 64'd0);
        check("rst.fmt",   {61'd0, bus.fmt_o},   64'd0);
        check("rst.imm",   bus.imm_o,            64'd0);

        // Release mid-cycle, away from the rising edge.
        @(negedge clk);
        rst_n       = 1'b1;
        bus.valid_i = 1'b0;

        // D-format.
        step("ldur5",  1'b1, LDUR5,    1'b1, 3'd4, 64'd5);
        step("ldurb",  1'b1, LDURB_M1, 1'b1, 3'd4, EXP_LDURB);
        // I-format, always zero-extended.
        step("addi3",  1'b1, ADDI3,    1'b1, 3'd5, 64'd3);
        step("orri",   1'b1, ORRI_FFF, 1'b1, 3'd5, 64'hFFF);
        // Branches.
        step("b128",   1'b1, B128,     1'b1, 3'd1, 64'd128);
        step("bl_m1",  1'b1, BL_M1,    1'b1, 3'd1, EXP_BL);
        step("cbnz16", 1'b1, CBNZ16,   1'b1, 3'd2, 64'd16);
        step("cbz_ng", 1'b1, CBZ_NEG,  1'b1, 3'd2, EXP_CBZ);
        step("bcond",  1'b1, BCOND_M1, 1'b1, 3'd3, EXP_BCOND);
        // Unrecognized R-format.
        step("add_r",  1'b1, ADD_R,    1'b1, 3'd0, 64'd0);

        // Hold: three idle cycles after a captured LDUR #5, garbage on instr.
        step("hold0",  1'b1, LDUR5,    1'b1, 3'd4, 64'd5);
        step("hold1",  1'b0, BCOND_M1, 1'b0, 3'd4, 64'd5);
        step("hold2",  1'b0, ORRI_FFF, 1'b0, 3'd4, 64'd5);
        step("hold3",  1'b0, 32'hFFFF_FFFF, 1'b0, 3'd4, 64'd5);

        // Back-to-back throughput; register fields must not matter.
        step("b2b0",   1'b1, B128,     1'b1, 3'd1, 64'd128);
        step("b2b1",   1'b1, ADDI3,    1'b1, 3'd5, 64'd3);
        step("b2b2",   1'b1, LDUR5_B,  1'b1, 3'd4, 64'd5);
        step("b2b3",   1'b1, CBNZ16,   1'b1, 3'd2, 64'd16);

        // Asynchronous reset mid-stream: outputs clear before any clock edge.
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.instr_i = ORRI_FFF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", {63'd0, bus.valid_o}, 64'd0);
        check("arst.fmt",   {61'd0, bus.fmt_o},   64'd0);
        check("arst.imm",   bus.imm_o,            64'd0);

        // Recover and confirm capture resumes.
        @(negedge clk);
        rst_n = 1'b1;
        step("post",   1'b1, ADDI3,    1'b1, 3'd5, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/legv8_sign_extend.md
# legv8_sign_extend

Registered immediate extractor and extender for the LEGv8 datapath, placed between instruction fetch/decode and the ALU/branch-target adder. It decodes the instruction format from the opcode bits and selects that format's immediate field. It then extends the field to 64 bits and registers the result with one cycle of latency. Branch offsets are delivered unshifted; the word shift (<<2) belongs to the branch adder.

## Interface

- No parameters.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- valid_i  input  1  instr_i is valid this cycle.
- instr_i  input  32  instruction word.
- valid_o  output  1  imm_o/fmt_o hold a result captured from a valid instruction.
- imm_o  output  64  extended immediate.
- fmt_o  output  3  decoded format: 0 NONE, 1 B, 2 CB, 3 BCOND, 4 D, 5 I.

## Operation

- Decode is combinational. The first matching rule wins, in this order:
  - **B/BL**: instr_i[30:26]==5'b00101. Field instr_i[25:0] (imm26). fmt 1.
  - **CBZ/CBNZ**: instr_i[31:25]==7'b1011010. Field instr_i[23:5] (imm19). fmt 2.
  - **B.cond**: instr_i[31:24]==8'b01010100. Field instr_i[23:5] (imm19). fmt 3.
  - **D-format** (LDUR/STUR/LDURB/STURB/LDURH/STURH/LDURSW/STURW): instr_i[29:24]==6'b111000. Field instr_i[20:12] (imm9). fmt 4.
  - **I-format** (ADDI/ADDIS/SUBI/SUBIS/ANDI/ANDIS/ORRI/EORI): instr_i[28:24] is 5'b10001 or 5'b10010, and instr_i[23:22]==2'b00. Field instr_i[21:10] (imm12). fmt 5.
  - **Anything else**: imm = 64'd0, fmt 0.
- I-format imm12 is always zero-extended.
- B, CB, BCOND and D fields are extended according to the Configuration section.
- When valid_i=1 on a rising clk edge:
  - imm_o and fmt_o take the decoded values.
  - valid_o goes to 1.
- When valid_i=0 on a rising clk edge:
  - imm_o and fmt_o hold their previous values.
  - valid_o goes to 0.
- The Rt/Rn/Rd and op2 fields never affect the outputs.

## Timing

- Latency is 1 cycle: an instruction sampled at edge N appears on the outputs after edge N. Back-to-back instructions are accepted every cycle, with no stall or backpressure.
- Reset values: imm_o=64'd0, fmt_o=3'd0, valid_o=0.
- Asserting rst_n=0 clears all three outputs immediately, independent of clk, including in the middle of a stream.
- The first capture after release is the first rising edge with rst_n=1 and valid_i=1.
- instr_i is don't-care when valid_i=0.

## Configuration

- Macro: LEGV8_SIGNED_OFFSET_EN.
- **Defined**: imm26, imm19 and imm9 are sign-extended. Bit 63 down to the field width replicates the field MSB (instr_i[25], instr_i[23] or instr_i[20] respectively).
- **Undefined**: those fields are zero-extended, so every immediate is unsigned.
- I-format zero-extension and the decode are identical in both builds.

## Test plan

- **Reset**: hold rst_n=0 with valid_i=1 and arbitrary instr_i across several edges. Required: imm_o=0, fmt_o=0, valid_o=0. Then deassert rst_n mid-cycle and reassert it asynchronously mid-stream; the outputs must clear without waiting for a clk edge.
- **D-format**: apply LDUR {11'b11111000010, 9'd5, 2'b00, 5'd1, 5'd2}. Required one cycle later: imm_o=5, fmt_o=4.
  - Then LDURB with imm9=9'h1FF. Required: 64'hFFFF_FFFF_FFFF_FFFF with the macro; 64'h1FF without it.
- **I-format**: apply ADDI {10'b1001000100, 12'd3, 5'd1, 5'd2}. Required: imm_o=3, fmt_o=5.
  - Then ORRI with imm12=12'hFFF. Required: imm_o=64'hFFF in both builds.
- **Branches**, each one cycle after the input:
  - B with imm26=128 → imm_o=128, fmt 1.
  - CBNZ {8'b10110101, 19'd16, 5'd0} → 16, fmt 2.
  - B.cond with imm19=19'h7FFFF → 64'hFFFF_FFFF_FFFF_FFFF with the macro, 64'h7FFFF without it; fmt 3.
- **Unrecognized**: apply ADD R-format 32'h8B020020. Required: imm_o=0, fmt_o=0, valid_o=1.
- **Hold and throughput**: drive valid_i=0 for 3 cycles after a captured LDUR #5. Required: imm_o stays 5, fmt_o stays 4, valid_o=0.
  - Then drive 4 back-to-back valid instructions. Required: each result appears exactly one cycle after its input.
